mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 145 ++++++++++++++
 tb/tb_mem_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// CPU/DMA arbiter in front of a byte-split (even/odd bank) synchronous RAM.
// Fixed three-cycle access: decide in IDLE, drive the banks in ACCESS, ack and capture read data in RESP.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches the winner's fields
// ACCESS | bank addresses and write strobes driven from the latched request
// RESP   | granted port's ack pulses; bank read data registered into its rdata
module mem_arb #(
  parameter int AW     = 12,
  parameter int STARVE = 4
) (
  input  logic          m_clock,
  input  logic          p_reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_byte,
  input  logic [15:0]   c_adrs,
  input  logic [15:0]   c_wdata,
  output logic [15:0]   c_rdata,
  output logic          c_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [15:0]   d_adrs,
  input  logic [15:0]   d_wdata,
  output logic [15:0]   d_rdata,
  output logic          d_ack,
  output logic [AW-2:0] me_adrs,
  output logic [AW-2:0] mo_adrs,
  output logic          me_we,
  output logic          mo_we,
  output logic [7:0]    me_wdata,
  output logic [7:0]    mo_wdata,
  input  logic [7:0]    me_rdata,
  input  logic [7:0]    mo_rdata
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  state_t        next_state;
  logic          lat_dma;
  logic          lat_we;
  logic          lat_byte;
  logic [AW-1:0] lat_adrs;
  logic [15:0]   lat_wdata;
  logic [SW-1:0] starve_cnt;
  logic          decide;
  logic          dma_win;
  logic          load_rd;
  logic [15:0]   rd_val;

  // Address bits above AW are ignored so accesses wrap around the memory.
  logic unused_adrs;
  assign unused_adrs = ^{c_adrs[15:AW], d_adrs[15:AW]};

  assign decide  = (state == IDLE) && (c_req || d_req);
  assign dma_win = d_req && (!c_req || (starve_cnt == STARVE_MAX));

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (c_req || d_req) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    c_ack   = 1'b0;
    d_ack   = 1'b0;
    me_we   = 1'b0;
    mo_we   = 1'b0;
    load_rd = 1'b0;
    unique case (state)
      ACCESS: begin
        me_we = lat_we && (!lat_byte || !lat_adrs[0]);
        mo_we = lat_we && (!lat_byte ||  lat_adrs[0]);
      end
      RESP: begin
        c_ack   = !lat_dma;
        d_ack   =  lat_dma;
        load_rd = !lat_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      lat_dma   <= 1'b0;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      lat_adrs  <= '0;
      lat_wdata <= '0;
    end else if (decide) begin
      lat_dma   <= dma_win;
      lat_we    <= dma_win ? d_we    : c_we;
      lat_byte  <= dma_win ? d_byte  : c_byte;
      lat_adrs  <= dma_win ? d_adrs[AW-1:0] : c_adrs[AW-1:0];
      lat_wdata <= dma_win ? d_wdata : c_wdata;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      starve_cnt <= '0;
    end else if (decide) begin
      if (dma_win)
        starve_cnt <= '0;
      else if (d_req && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Both banks see the same word index; the byte lane is chosen by strobes and read mux.
  assign me_adrs  = lat_adrs[AW-1:1];
  assign mo_adrs  = lat_adrs[AW-1:1];
  assign me_wdata = lat_byte ? lat_wdata[7:0] : lat_wdata[15:8];
  assign mo_wdata = lat_wdata[7:0];

  assign rd_val = lat_byte ? {8'h00, (lat_adrs[0] ? mo_rdata : me_rdata)}
                           : {me_rdata, mo_rdata};

  // rdata is captured at the end of RESP and holds until that port's next read.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      c_rdata <= '0;
      d_rdata <= '0;
    end else if (load_rd) begin
      if (lat_dma) d_rdata <= rd_val;
      else         c_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: bank RAM model plus a flat byte-array reference memory.
module tb_mem_arb;
  localparam int AW     = 12;
  localparam int STARVE = 4;

  logic          m_clock = 1'b0;
  logic          p_reset = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0, c_byte = 1'b0;
  logic [15:0]   c_adrs = '0, c_wdata = '0;
  logic [15:0]   c_rdata;
  logic          c_ack;
  logic          d_req = 1'b0, d_we = 1'b0, d_byte = 1'b0;
  logic [15:0]   d_adrs = '0, d_wdata = '0;
  logic [15:0]   d_rdata;
  logic          d_ack;
  logic [AW-2:0] me_adrs, mo_adrs;
  logic          me_we, mo_we;
  logic [7:0]    me_wdata, mo_wdata;
  logic [7:0]    me_rdata = '0, mo_rdata = '0;

  logic [7:0]  ram_e [0:2**(AW-1)-1];
  logic [7:0]  ram_o [0:2**(AW-1)-1];
  logic [7:0]  ref_mem [0:2**AW-1];
  logic [15:0] prev_rd [0:1];

  int n_tests = 0;
  int n_fail  = 0;

  mem_arb #(.AW(AW), .STARVE(STARVE)) dut (
    .m_clock (m_clock),  .p_reset (p_reset),
    .c_req   (c_req),    .c_we    (c_we),    .c_byte (c_byte),
    .c_adrs  (c_adrs),   .c_wdata (c_wdata), .c_rdata (c_rdata), .c_ack (c_ack),
    .d_req   (d_req),    .d_we    (d_we),    .d_byte (d_byte),
    .d_adrs  (d_adrs),   .d_wdata (d_wdata), .d_rdata (d_rdata), .d_ack (d_ack),
    .me_adrs (me_adrs),  .mo_adrs (mo_adrs),
    .me_we   (me_we),    .mo_we   (mo_we),
    .me_wdata(me_wdata), .mo_wdata(mo_wdata),
    .me_rdata(me_rdata), .mo_rdata(mo_rdata)
  );

  always #5 m_clock = ~m_clock;

  // Synchronous RAM banks: data appears one cycle after the address.
  always @(posedge m_clock) begin
    if (me_we) ram_e[me_adrs] <= me_wdata;
    if (mo_we) ram_o[mo_adrs] <= mo_wdata;
    me_rdata <= ram_e[me_adrs];
    mo_rdata <= ram_o[mo_adrs];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input bit bsel, input logic [11:0] a);
    if (bsel) return {8'h00, ref_mem[a]};
    return {ref_mem[{a[11:1], 1'b0}], ref_mem[{a[11:1], 1'b1}]};
  endfunction

  task automatic ref_write(input bit bsel, input logic [11:0] a, input logic [15:0] wd);
    if (bsel) ref_mem[a] = wd[7:0];
    else begin
      ref_mem[{a[11:1], 1'b0}] = wd[15:8];
      ref_mem[{a[11:1], 1'b1}] = wd[7:0];
    end
  endtask

  // Called at a negedge while the arbiter is idle; returns at the negedge after rdata settles.
  task automatic do_xfer(input bit dma, input bit we, input bit bsel,
                         input logic [15:0] adrs, input logic [15:0] wdata);
    logic [11:0] a;
    logic [15:0] exp;
    int cyc, ne, no, bad, exp_e, exp_o;
    bit got;
    a = adrs[11:0];
    if (dma) begin
      d_req = 1'b1; d_we = we; d_byte = bsel; d_adrs = adrs; d_wdata = wdata;
    end else begin
      c_req = 1'b1; c_we = we; c_byte = bsel; c_adrs = adrs; c_wdata = wdata;
    end
    cyc = 0; ne = 0; no = 0; bad = 0; got = 1'b0;
    while (!got && cyc < 8) begin
      @(negedge m_clock);
      cyc++;
      ne += int'(me_we);
      no += int'(mo_we);
      if (cyc == 1) check("bank_adrs", 32'({me_adrs, mo_adrs}), 32'({a[11:1], a[11:1]}));
      if (dma ? d_ack : c_ack) got = 1'b1;
      if (dma ? c_ack : d_ack) bad++;
    end
    check("ack_latency", cyc, 2);
    check("other_ack", bad, 0);
    if (dma) d_req = 1'b0; else c_req = 1'b0;
    exp_e = (we && (!bsel || !a[0])) ? 1 : 0;
    exp_o = (we && (!bsel ||  a[0])) ? 1 : 0;
    check("we_pulses", ne * 16 + no, exp_e * 16 + exp_o);
    if (we) begin
      ref_write(bsel, a, wdata);
      exp = prev_rd[dma];
    end else begin
      exp = ref_read(bsel, a);
      prev_rd[dma] = exp;
    end
    @(negedge m_clock);
    check(dma ? "d_rdata" : "c_rdata", dma ? d_rdata : c_rdata, exp);
  endtask

  initial begin
    int grants, losses, ack_seen;
    bit exp_d;
    for (int i = 0; i < 2**(AW-1); i++) begin ram_e[i] = 8'h00; ram_o[i] = 8'h00; end
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = 8'h00;
    prev_rd[0] = '0; prev_rd[1] = '0;

    repeat (3) @(negedge m_clock);
    check("rst_ack_we", 32'({c_ack, d_ack, me_we, mo_we}), 0);
    check("rst_rdata", 32'({c_rdata, d_rdata}), 0);
    check("rst_bank_adrs", 32'({me_adrs, mo_adrs}), 0);
    check("rst_bank_wdata", 32'({me_wdata, mo_wdata}), 0);
    p_reset = 1'b1;
    @(negedge m_clock);

    // Directed word/byte accesses and address wrap
    do_xfer(0, 1, 0, 16'h0010, 16'h1234);
    check("even8_word", ram_e[8], 8'h12);
    check("odd8_word", ram_o[8], 8'h34);
    do_xfer(0, 0, 0, 16'h0010, 16'h0000);
    do_xfer(0, 1, 1, 16'h0011, 16'h00AB);
    check("odd8_byte", ram_o[8], 8'hAB);
    check("even8_kept", ram_e[8], 8'h12);
    do_xfer(0, 0, 1, 16'h0011, 16'h0000);
    do_xfer(0, 0, 0, 16'hF010, 16'h0000);
    do_xfer(1, 0, 1, 16'h3010, 16'h0000);

    // Random single-requester traffic in a small window with random upper address bits
    repeat (40) begin
      do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              {4'($urandom_range(0, 15)), 8'h02, 4'($urandom_range(0, 15))}, 16'($urandom));
    end

    // Both ports requesting continuously: DMA gets every (STARVE+1)th grant
    c_req = 1'b1; c_we = 1'b0; c_byte = 1'b0; c_adrs = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_adrs = 16'h0010;
    grants = 0; losses = 0;
    for (int cyc = 1; cyc <= 44; cyc++) begin
      @(negedge m_clock);
      ack_seen = int'(c_ack) + int'(d_ack);
      if (ack_seen != 0) begin
        exp_d = (losses == STARVE);
        check("grant_order", 32'({c_ack, d_ack}), exp_d ? 32'h1 : 32'h2);
        if (exp_d) losses = 0;
        else if (losses < STARVE) losses++;
        grants++;
      end
    end
    c_req = 1'b0; d_req = 1'b0;
    check("grant_count", grants, 15);
    prev_rd[0] = ref_read(0, 12'h010);
    prev_rd[1] = ref_read(0, 12'h010);
    @(negedge m_clock);
    check("starve_c_rdata", c_rdata, prev_rd[0]);
    check("starve_d_rdata", d_rdata, prev_rd[1]);

    // Reset during ACCESS of a write aborts it
    do_xfer(0, 1, 0, 16'h0040, 16'h5A5A);
    c_req = 1'b1; c_we = 1'b1; c_byte = 1'b0; c_adrs = 16'h0040; c_wdata = 16'hBEEF;
    @(negedge m_clock);
    check("abort_in_access", 32'({me_we, mo_we}), 32'h3);
    p_reset = 1'b0;
    #1;
    check("abort_ack_we", 32'({c_ack, d_ack, me_we, mo_we}), 0);
    check("abort_rdata", 32'({c_rdata, d_rdata}), 0);
    check("abort_bank", 32'({me_adrs, mo_adrs}), 0);
    check("abort_wdata", 32'({me_wdata, mo_wdata}), 0);
    c_req = 1'b0;
    ack_seen = 0;
    repeat (3) begin
      @(negedge m_clock);
      ack_seen += int'(c_ack) + int'(d_ack);
    end
    check("abort_no_ack", ack_seen, 0);
    check("abort_mem_even", ram_e[12'h020], 8'h5A);
    check("abort_mem_odd", ram_o[12'h020], 8'h5A);
    p_reset = 1'b1;
    prev_rd[0] = '0; prev_rd[1] = '0;
    do_xfer(0, 0, 0, 16'h0040, 16'h0000);
    do_xfer(1, 0, 0, 16'h0040, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
